// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU has priority, and a starvation counter forces bounded host bursts while stalling the core.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int HOST_BURST_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_host_gnts,
  output logic [31:0]       stat_cpu_stalls
`endif
);

  localparam int WAIT_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BURST_W = $clog2(HOST_BURST_MAX + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(HOST_BURST_MAX - 1);

  typedef enum logic [0:0] {S_CPU = 1'b0, S_HOST = 1'b1} state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic                rd_owner_host;
  logic                cpu_req;
  logic                cpu_gnt;
  logic                host_gnt_c;
  logic                force_host;
  logic                in_burst;

  assign cpu_req  = cpu_rden | cpu_wren;
  assign in_burst = (state == S_HOST) && host_req;

  // Grant decision; S_HOST without a host request falls back to S_CPU rules.
  always_comb begin
    cpu_gnt    = 1'b0;
    host_gnt_c = 1'b0;
    force_host = 1'b0;
    if (in_burst) begin
      host_gnt_c = 1'b1;
    end else if (host_req && !cpu_req) begin
      host_gnt_c = 1'b1;
    end else if (cpu_req && !host_req) begin
      cpu_gnt = 1'b1;
    end else if (cpu_req && host_req) begin
      if (wait_cnt == WAIT_LAST) begin
        host_gnt_c = 1'b1;
        force_host = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else begin
      cpu_gnt = 1'b0;
    end
  end

  assign host_gnt  = host_gnt_c;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_q     = mem_q;

  // Memory port mux: exactly one owner, or an idle port.
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (host_gnt_c) begin
      mem_address = host_addr;
      mem_data    = host_wdata;
      mem_rden    = ~host_we;
      mem_wren    = host_we;
    end else if (cpu_gnt) begin
      mem_address = cpu_address;
      mem_data    = cpu_data;
      mem_rden    = cpu_rden;
      mem_wren    = cpu_wren;
    end else begin
      mem_rden    = 1'b0;
    end
  end

  // Arbitration state, starvation/burst counters and read-owner tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_CPU;
      wait_cnt      <= '0;
      burst_cnt     <= '0;
      rd_owner_host <= 1'b0;
    end else begin
      rd_owner_host <= host_gnt_c & ~host_we;
      if (in_burst) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
        state     <= (burst_cnt == BURST_LAST) ? S_CPU : S_HOST;
      end else begin
        state <= S_CPU;
        if (!host_req || !cpu_req) begin
          wait_cnt <= '0;
        end else if (force_host) begin
          wait_cnt  <= '0;
          burst_cnt <= BURST_W'(1);
          state     <= (HOST_BURST_MAX == 1) ? S_CPU : S_HOST;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end
    end
  end

  // Gating with rst drops a read that was in flight when reset arrived.
  assign host_rvalid = rd_owner_host & ~rst;
  assign host_rdata  = host_rvalid ? mem_q : '0;

`ifdef DMEM_ARB_STATS_EN
  // Saturating grant and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_host_gnts  <= 32'd0;
      stat_cpu_stalls <= 32'd0;
    end else begin
      if (host_gnt_c && (stat_host_gnts != 32'hFFFF_FFFF)) begin
        stat_host_gnts <= stat_host_gnts + 32'd1;
      end
      if (cpu_stall && (stat_cpu_stalls != 32'hFFFF_FFFF)) begin
        stat_cpu_stalls <= stat_cpu_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle expectations and host read data,
// and a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cpu_address = 10'd0;
  logic [31:0] cpu_data = 32'd0;
  logic        cpu_rden = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [9:0]  host_addr = 10'd0;
  logic [31:0] host_wdata = 32'd0;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_q = 32'd0;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_host_gnts;
  logic [31:0] stat_cpu_stalls;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef DMEM_ARB_STATS_EN
    , .stat_host_gnts(stat_host_gnts), .stat_cpu_stalls(stat_cpu_stalls)
`endif
  );

  always #5 clk = ~clk;

  // DataMem model: registered read, one-cycle latency
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_address];
  end

  typedef struct {
    logic [5:0]  e;   // {host_gnt, cpu_stall, mem_rden, mem_wren, host_rvalid, check_cpu_q}
    logic [31:0] q;
  } exp_t;

  exp_t        ctl_q[$];
  logic [31:0] hq[$];
  int          total = 0;
  int          bad = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (ctl_q.size() > 0) begin
      x = ctl_q.pop_front();
      chk("host_gnt",    {31'd0, host_gnt},    {31'd0, x.e[5]});
      chk("cpu_stall",   {31'd0, cpu_stall},   {31'd0, x.e[4]});
      chk("mem_rden",    {31'd0, mem_rden},    {31'd0, x.e[3]});
      chk("mem_wren",    {31'd0, mem_wren},    {31'd0, x.e[2]});
      chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, x.e[1]});
      if (x.e[0]) chk("cpu_q", cpu_q, x.q);
    end
    if (host_rvalid) begin
      if (hq.size() > 0) chk("host_rdata", host_rdata, hq.pop_front());
      else chk("host_rvalid_unexpected", {31'd0, host_rvalid}, 32'd0);
    end
  end

  task automatic step(input logic r, input logic crd, input logic cwr, input logic [9:0] ca,
                      input logic [31:0] cd, input logic hr, input logic hw, input logic [9:0] ha,
                      input logic [31:0] hd, input logic [5:0] e, input logic [31:0] eq);
    exp_t x;
    rst = r; cpu_rden = crd; cpu_wren = cwr; cpu_address = ca; cpu_data = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    x.e = e; x.q = eq;
    ctl_q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [5:0] e, input logic [31:0] eq);
    step(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, e, eq);
  endtask

  // CPU reads addr 5 while host reads addr 7 (which holds 0x12345678)
  task automatic both(input logic [5:0] e, input logic [31:0] eq);
    if (e[5]) hq.push_back(32'h1234_5678);
    step(1'b0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 10'd7, 32'd0, e, eq);
  endtask

  initial begin
    @(posedge clk); #1;
    // reset with no requests
    step(1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 6'b000000, 32'd0);
    step(1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 6'b000000, 32'd0);
    // CPU write then read of addr 5
    step(1'b0, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 10'd0, 32'd0, 6'b000100, 32'd0);
    step(1'b0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 6'b001000, 32'd0);
    idle(6'b000001, 32'hDEAD_BEEF);
    // host write addr 7, then host read addr 5 with CPU idle
    step(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 10'd7, 32'h1234_5678, 6'b100100, 32'd0);
    hq.push_back(32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0, 6'b101000, 32'd0);
    idle(6'b000010, 32'd0);
    // contention: 3 CPU cycles, 2 forced host cycles, repeated
    both(6'b001000, 32'd0);
    both(6'b001001, 32'hDEAD_BEEF);
    both(6'b001001, 32'hDEAD_BEEF);
    both(6'b111001, 32'hDEAD_BEEF);
    both(6'b111010, 32'd0);
    both(6'b001010, 32'd0);
    both(6'b001001, 32'hDEAD_BEEF);
    both(6'b001001, 32'hDEAD_BEEF);
    both(6'b111001, 32'hDEAD_BEEF);
    both(6'b111010, 32'd0);
    // host drops after the first forced grant
    both(6'b001010, 32'd0);
    both(6'b001001, 32'hDEAD_BEEF);
    both(6'b001001, 32'hDEAD_BEEF);
    both(6'b111001, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 6'b001010, 32'd0);
    both(6'b001001, 32'hDEAD_BEEF);
    idle(6'b000001, 32'hDEAD_BEEF);
    // host read granted, then reset in the response cycle: response is dropped
    step(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0, 6'b101000, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_host_gnts_pre",  stat_host_gnts,  32'd8);
    chk("stat_cpu_stalls_pre", stat_cpu_stalls, 32'd5);
`endif
    step(1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 6'b000000, 32'd0);
    idle(6'b000000, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_host_gnts_rst",  stat_host_gnts,  32'd0);
    chk("stat_cpu_stalls_rst", stat_cpu_stalls, 32'd0);
`endif
    idle(6'b000000, 32'd0);
    @(negedge clk); #1;
    chk("ctl_q_drained", ctl_q.size(), 32'd0);
    chk("hq_drained",    hq.size(),    32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
